// File: rtl/histogram_readout.sv
`default_nettype none
// ============================================================================
// Module   : histogram_readout
// Purpose  : Drains the histogram RAM as a header/bins/checksum word stream,
//            optionally zeroing each bin behind the read.
// Revision : 1.0
// ============================================================================
module histogram_readout #(
    parameter int          NUM_BINS      = 1024,
    parameter int          ADDR_W        = 10,
    parameter int          DATA_W        = 32,
    parameter bit          CLEAR_ON_READ = 1'b1,
    parameter logic [7:0]  HDR_TAG       = 8'hA5
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic              RamOwn,
    output logic [ADDR_W-1:0] RdAddress,
    input  logic [DATA_W-1:0] Q,
    output logic [ADDR_W-1:0] WrAddress,
    output logic [DATA_W-1:0] Data,
    output logic              WE,
    output logic              WrClockEn,
    output logic [DATA_W-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              OutFirst,
    output logic              OutLast
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_BINS = 3'd2,
        S_TRL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [15:0]     c_BIN_COUNT = 16'(NUM_BINS);
    localparam logic [ADDR_W:0] c_BIN_LIMIT = (ADDR_W+1)'(NUM_BINS);

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W:0]   r_rdCnt;
    logic [ADDR_W-1:0] r_capAddr;
    logic              r_inFlight;
    logic [DATA_W-1:0] r_buf [2];
    logic              r_wrPtr;
    logic              r_rdPtr;
    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_checksum;
    logic [7:0]        r_frameId;

    logic              w_accept;
    logic              w_pop;
    logic              w_issue;
    logic              w_clear;
    logic [2:0]        w_occupancy;
    logic [DATA_W-1:0] w_header;

    assign w_accept    = (r_state == S_IDLE) && Start;
    assign w_pop       = (r_state == S_BINS) && (r_count != 2'd0) && OutReady;
    // Occupancy after this cycle's pop; a new read may fill the freed slot.
    assign w_occupancy = 3'(r_count) + 3'(r_inFlight) - 3'(w_pop);
    assign w_issue     = (r_state == S_BINS) && (r_rdCnt < c_BIN_LIMIT) && (w_occupancy < 3'd2);
    assign w_clear     = r_inFlight && CLEAR_ON_READ;
    assign w_header    = DATA_W'({HDR_TAG, r_frameId, c_BIN_COUNT});

    assign RdAddress = r_rdCnt[ADDR_W-1:0];
    assign WrAddress = r_capAddr;
    assign Data      = '0;
    assign WE        = w_clear;
    assign WrClockEn = w_issue || w_clear;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        Busy        = 1'b0;
        RamOwn      = 1'b0;
        Done        = 1'b0;
        OutValid    = 1'b0;
        OutData     = '0;
        OutFirst    = 1'b0;
        OutLast     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) w_nextState = S_HDR;
            end
            S_HDR: begin
                Busy     = 1'b1;
                RamOwn   = 1'b1;
                OutValid = 1'b1;
                OutFirst = 1'b1;
                OutData  = w_header;
                if (OutReady) w_nextState = S_BINS;
            end
            S_BINS: begin
                Busy     = 1'b1;
                RamOwn   = 1'b1;
                OutValid = (r_count != 2'd0);
                OutData  = r_buf[r_rdPtr];
                // Last bin leaves when every read is issued, none pending, one left.
                if (w_pop && (r_count == 2'd1) && !r_inFlight && (r_rdCnt == c_BIN_LIMIT))
                    w_nextState = S_TRL;
            end
            S_TRL: begin
                Busy     = 1'b1;
                RamOwn   = 1'b1;
                OutValid = 1'b1;
                OutLast  = 1'b1;
                OutData  = r_checksum;
                if (OutReady) w_nextState = S_DONE;
            end
            S_DONE: begin
                Done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rdCnt    <= '0;
            r_capAddr  <= '0;
            r_inFlight <= 1'b0;
            r_buf      <= '{default: '0};
            r_wrPtr    <= 1'b0;
            r_rdPtr    <= 1'b0;
            r_count    <= 2'd0;
            r_checksum <= '0;
            r_frameId  <= 8'd0;
        end else begin
            if (w_accept) begin
                r_rdCnt    <= '0;
                r_inFlight <= 1'b0;
                r_wrPtr    <= 1'b0;
                r_rdPtr    <= 1'b0;
                r_count    <= 2'd0;
                r_checksum <= '0;
            end else begin
                r_inFlight <= w_issue;
                if (w_issue) begin
                    r_capAddr <= RdAddress;
                    r_rdCnt   <= r_rdCnt + 1'b1;
                end
                if (r_inFlight) begin
                    r_buf[r_wrPtr] <= Q;
                    r_wrPtr        <= ~r_wrPtr;
                    r_checksum     <= r_checksum + Q;
                end
                if (w_pop) r_rdPtr <= ~r_rdPtr;
                r_count <= r_count + 2'(r_inFlight) - 2'(w_pop);
            end
            if (r_state == S_DONE) r_frameId <= r_frameId + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_histogram_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_histogram_readout
// Purpose  : Directed self-checking bench for histogram_readout with RAM models.
// Revision : 1.0
// ============================================================================
module tb_histogram_readout;

    localparam int NB    = 1024;
    localparam int NB2   = 16;
    localparam int LIMIT = 6000;

    logic Clock   = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clock = ~Clock;

    logic        startA = 1'b0, readyA = 1'b0;
    logic        busyA, doneA, ownA, weA, ceA, validA, firstA, lastA;
    logic [9:0]  rdA, wrA;
    logic [31:0] qA, dA, outA;

    logic        startB = 1'b0, readyB = 1'b0;
    logic        busyB, doneB, ownB, weB, ceB, validB, firstB, lastB;
    logic [3:0]  rdB, wrB;
    logic [31:0] qB, dB, outB;

    histogram_readout u_dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(startA), .Busy(busyA), .Done(doneA),
        .RamOwn(ownA), .RdAddress(rdA), .Q(qA), .WrAddress(wrA), .Data(dA), .WE(weA),
        .WrClockEn(ceA), .OutData(outA), .OutValid(validA), .OutReady(readyA),
        .OutFirst(firstA), .OutLast(lastA)
    );

    histogram_readout #(.NUM_BINS(NB2), .ADDR_W(4), .CLEAR_ON_READ(1'b0)) u_dutNc (
        .Clock(Clock), .Reset_n(Reset_n), .Start(startB), .Busy(busyB), .Done(doneB),
        .RamOwn(ownB), .RdAddress(rdB), .Q(qB), .WrAddress(wrB), .Data(dB), .WE(weB),
        .WrClockEn(ceB), .OutData(outB), .OutValid(validB), .OutReady(readyB),
        .OutFirst(firstB), .OutLast(lastB)
    );

    // RAM models: one clock enable shared by the read and write ports
    logic [31:0] ramA [NB];
    logic [31:0] ramB [NB2];
    logic        loadReq = 1'b0;
    int          loadPat = 0;

    always @(posedge Clock) begin
        if (loadReq) begin
            for (int i = 0; i < NB; i++)  ramA[i] <= (loadPat == 1) ? 32'hFFFF_FFFF : 32'(i + 1);
            for (int i = 0; i < NB2; i++) ramB[i] <= 32'(i * 7 + 3);
        end else begin
            if (ceA) begin
                qA <= ramA[rdA];
                if (weA) ramA[wrA] <= dA;
            end
            if (ceB) begin
                qB <= ramB[rdB];
                if (weB) ramB[wrB] <= dB;
            end
        end
    end

    // Stream monitors
    logic [31:0] wordsA[$], wordsB[$];
    logic [1:0]  flagsA[$], flagsB[$];
    int          weCntA = 0, doneCntA = 0, stallErrA = 0, excErrA = 0;
    int          weCntB = 0, doneCntB = 0;
    logic        pendA = 1'b0;
    logic [31:0] pendDataA = 32'd0;

    always @(negedge Clock) begin
        if (!Reset_n) begin
            pendA <= 1'b0;
        end else begin
            if (pendA && !(validA && outA == pendDataA)) stallErrA <= stallErrA + 1;
            if ((firstA && lastA) || (validA && !busyA)) excErrA <= excErrA + 1;
            if (validA && readyA) begin
                wordsA.push_back(outA);
                flagsA.push_back({firstA, lastA});
            end
            pendA     <= validA && !readyA;
            pendDataA <= outA;
            if (weA)   weCntA   <= weCntA + 1;
            if (doneA) doneCntA <= doneCntA + 1;
            if (validB && readyB) begin
                wordsB.push_back(outB);
                flagsB.push_back({firstB, lastB});
            end
            if (weB)   weCntB   <= weCntB + 1;
            if (doneB) doneCntB <= doneCntB + 1;
        end
    end

    int nCompared = 0;
    int nMismatch = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expBin(input int pat, input int i);
        case (pat)
            0:       return 32'(i + 1);
            1:       return 32'hFFFF_FFFF;
            3:       return 32'(i * 7 + 3);
            default: return 32'h0;
        endcase
    endfunction

    task automatic preload(input int pat);
        loadPat = pat;
        @(posedge Clock); #1 loadReq = 1'b1;
        @(posedge Clock); #1 loadReq = 1'b0;
    endtask

    task automatic snap(input bit sel, output int bw, output int bd, output int bwe);
        bw  = sel ? wordsB.size() : wordsA.size();
        bd  = sel ? doneCntB : doneCntA;
        bwe = sel ? weCntB : weCntA;
    endtask

    task automatic runDump(input bit sel, input bit randReady, input bit pulseMid, output int cycles);
        int doneBase;
        doneBase = sel ? doneCntB : doneCntA;
        cycles = 0;
        @(posedge Clock); #1;
        if (sel) startB = 1'b1; else startA = 1'b1;
        @(posedge Clock); #1;
        startA = 1'b0;
        startB = 1'b0;
        while ((sel ? doneCntB : doneCntA) == doneBase && cycles < LIMIT) begin
            if (sel) readyB = 1'b1;
            else     readyA = randReady ? ($urandom_range(0, 9) >= 3) : 1'b1;
            if (!sel) startA = pulseMid && (cycles == 200);
            @(posedge Clock); #1;
            cycles++;
        end
        readyA = 1'b0;
        readyB = 1'b0;
        startA = 1'b0;
        checkVal("dumpFinished", 64'(cycles < LIMIT), 64'd1);
    endtask

    task automatic checkDump(input bit sel, input int bw, input int bd, input int bwe,
                             input logic [31:0] hdr, input int pat, input logic [31:0] trl,
                             input int expWe);
        logic [31:0] w[$];
        logic [1:0]  f[$];
        int nb, n, binErr, flagErr;
        repeat (3) @(posedge Clock);
        #1;
        if (sel) begin w = wordsB; f = flagsB; end
        else     begin w = wordsA; f = flagsA; end
        nb = sel ? NB2 : NB;
        n  = w.size() - bw;
        checkVal("wordCount", 64'(n), 64'(nb + 2));
        checkVal("donePulses", 64'((sel ? doneCntB : doneCntA) - bd), 64'd1);
        checkVal("clearWrites", 64'((sel ? weCntB : weCntA) - bwe), 64'(expWe));
        if (n == nb + 2) begin
            binErr  = 0;
            flagErr = 0;
            for (int i = 0; i < nb; i++)
                if (w[bw + 1 + i] !== expBin(pat, i)) binErr++;
            for (int i = 0; i < nb + 2; i++)
                if (f[bw + i] !== ((i == 0) ? 2'b10 : (i == nb + 1) ? 2'b01 : 2'b00)) flagErr++;
            checkVal("header", 64'(w[bw]), 64'(hdr));
            checkVal("trailer", 64'(w[bw + nb + 1]), 64'(trl));
            checkVal("binWords", 64'(binErr), 64'd0);
            checkVal("firstLastFlags", 64'(flagErr), 64'd0);
        end
    endtask

    function automatic int ramNonZeroA();
        int cnt = 0;
        for (int i = 0; i < NB; i++) if (ramA[i] != 32'd0) cnt++;
        return cnt;
    endfunction

    initial begin
        int bw, bd, bwe, cyc, k, errs;

        #12;
        checkVal("resetOutputs", 64'({busyA, doneA, ownA, weA, ceA, validA, firstA, lastA, rdA, wrA, outA}), 64'd0);
        @(posedge Clock); #1 Reset_n = 1'b1;

        // Back-to-back dumps; a stray Start during the first must be ignored
        preload(0);
        snap(1'b0, bw, bd, bwe);
        runDump(1'b0, 1'b0, 1'b1, cyc);
        checkVal("fullRateCycles", 64'(cyc <= NB + 12), 64'd1);
        checkDump(1'b0, bw, bd, bwe, 32'hA500_0400, 0, 32'h0008_0200, NB);
        checkVal("ramClearedAfterDump", 64'(ramNonZeroA()), 64'd0);
        snap(1'b0, bw, bd, bwe);
        runDump(1'b0, 1'b0, 1'b0, cyc);
        checkDump(1'b0, bw, bd, bwe, 32'hA501_0400, 2, 32'h0, NB);

        // Random backpressure
        preload(0);
        snap(1'b0, bw, bd, bwe);
        runDump(1'b0, 1'b1, 1'b0, cyc);
        checkDump(1'b0, bw, bd, bwe, 32'hA502_0400, 0, 32'h0008_0200, NB);
        checkVal("ramClearedAfterStalls", 64'(ramNonZeroA()), 64'd0);

        // Checksum wraps modulo 2^32
        preload(1);
        snap(1'b0, bw, bd, bwe);
        runDump(1'b0, 1'b0, 1'b0, cyc);
        checkDump(1'b0, bw, bd, bwe, 32'hA503_0400, 1, 32'hFFFF_FC00, NB);

        // Reset in the middle of the bin phase
        preload(0);
        snap(1'b0, bw, bd, bwe);
        @(posedge Clock); #1 startA = 1'b1;
        @(posedge Clock); #1 startA = 1'b0;
        readyA = 1'b1;
        k = 0;
        do begin
            @(negedge Clock);
            k++;
        end while (!(busyA && ceA && rdA == 10'd300) && k < LIMIT);
        checkVal("reachedAddr300", 64'(k < LIMIT), 64'd1);
        Reset_n = 1'b0;
        #1;
        checkVal("asyncResetOutputs", 64'({busyA, doneA, ownA, weA, ceA, validA, firstA, lastA, rdA, wrA, outA}), 64'd0);
        readyA = 1'b0;
        @(posedge Clock); #1 Reset_n = 1'b1;
        repeat (5) @(posedge Clock);
        #1;
        checkVal("noDoneAfterReset", 64'(doneCntA - bd), 64'd0);
        errs = 0;
        for (int i = 0; i < NB; i++) begin
            if (i < 299 && ramA[i] != 32'd0) errs++;
            if (i == 299 && ramA[i] != 32'd0 && ramA[i] != 32'd300) errs++;
            if (i > 299 && ramA[i] != 32'(i + 1)) errs++;
        end
        checkVal("partialClear", 64'(errs), 64'd0);
        preload(0);
        snap(1'b0, bw, bd, bwe);
        runDump(1'b0, 1'b0, 1'b0, cyc);
        checkDump(1'b0, bw, bd, bwe, 32'hA500_0400, 0, 32'h0008_0200, NB);

        // No clearing: two identical dumps
        snap(1'b1, bw, bd, bwe);
        runDump(1'b1, 1'b0, 1'b0, cyc);
        checkDump(1'b1, bw, bd, bwe, 32'hA500_0010, 3, 32'h0000_0378, 0);
        snap(1'b1, bw, bd, bwe);
        runDump(1'b1, 1'b0, 1'b0, cyc);
        checkDump(1'b1, bw, bd, bwe, 32'hA501_0010, 3, 32'h0000_0378, 0);
        checkVal("ncIdle", 64'({busyB, ownB}), 64'd0);

        checkVal("stallHold", 64'(stallErrA), 64'd0);
        checkVal("validAndFlagRules", 64'(excErrA), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
`default_nettype wire
